// File: rtl/sam_dmem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sam_dmem_responder_pkg
// Purpose  : Shared FSM state encoding and constants for the data-memory
//            responder and its storage array.
// Revision : 1.0 - initial release
// ============================================================================
package sam_dmem_responder_pkg;

  // Responder FSM states, 2-bit encoding shared with memory-side loaders
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // Byte-enable value that writes a full 32-bit word
  localparam logic [3:0] BE_ALL = 4'hF;

endpackage
`default_nettype wire

// File: rtl/sam_dmem_array.sv
`default_nettype none
// ============================================================================
// Module   : sam_dmem_array
// Purpose  : Single-port DEPTH x 32 RAM, byte-enabled write, registered read.
//            No reset: contents survive responder resets.
// Revision : 1.0 - initial release
// ============================================================================
module sam_dmem_array #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        be,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH];

  // One access per enabled cycle: byte-masked write, or read into the output register
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) begin
            mem[addr][8*i +: 8] <= wdata[8*i +: 8];
          end
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sam_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : sam_dmem_responder
// Purpose  : Slave end of the MEM-stage load/store port. Accepts one request,
//            waits WAIT_CYCLES, accesses the array, returns a held response.
// Revision : 1.0 - initial release
// ============================================================================
module sam_dmem_responder
  import sam_dmem_responder_pkg::*;
#(
  parameter int DEPTH       = 32,
  parameter int ADDR_W      = 5,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        RN,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);
  localparam logic [3:0]  WAIT_W  = 4'(WAIT_CYCLES);

  state_t      state;
  state_t      next_state;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic [3:0]  wait_cnt;
  logic        rdata_sel;
  logic        addr_err;
  logic        arr_en;
  logic [31:0] arr_rdata;
  logic        rsp_hs;

  // Range check on the latched word address: upper bits must be zero and the index below DEPTH
  always_comb begin
    addr_err = (addr_q[31:ADDR_W] != '0) ||
               ({{(32-ADDR_W){1'b0}}, addr_q[ADDR_W-1:0]} >= DEPTH_W);
  end

  // A reset landing on the ACCESS edge cancels the access, so gate the array with RN
  assign arr_en = (state == ST_ACCESS) && !addr_err && RN;
  assign rsp_hs = (state == ST_RESP) && rsp_ready;

  sam_dmem_array #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .en    (arr_en),
    .we    (we_q),
    .addr  (addr_q[ADDR_W-1:0]),
    .be    (be_q & BE_ALL),
    .wdata (wdata_q),
    .rdata (arr_rdata)
  );

  // Load data comes straight from the array's read register; stores and errors return zero
  assign rsp_rdata = rdata_sel ? arr_rdata : 32'd0;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!RN) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          next_state = (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;
        end
      end
      ST_WAIT: begin
        if (wait_cnt == 4'd1) begin
          next_state = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        next_state = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Request latches and wait-state counter
  always_ff @(posedge clk) begin
    if (!RN) begin
      we_q     <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      be_q     <= 4'd0;
      wait_cnt <= 4'd0;
    end else if ((state == ST_IDLE) && req_valid) begin
      we_q     <= req_we;
      addr_q   <= req_addr;
      wdata_q  <= req_wdata;
      be_q     <= req_be;
      wait_cnt <= WAIT_W;
    end else if (state == ST_WAIT) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  // Response registers: captured in ACCESS, held through RESP until the handshake
  always_ff @(posedge clk) begin
    if (!RN) begin
      rdata_sel <= 1'b0;
      rsp_err   <= 1'b0;
    end else if (state == ST_ACCESS) begin
      rdata_sel <= !we_q && !addr_err;
      rsp_err   <= addr_err;
    end
  end

  // Completed-transaction counters; errored accesses are not counted
  always_ff @(posedge clk) begin
    if (!RN) begin
      rd_count <= 16'd0;
      wr_count <= 16'd0;
    end else if (rsp_hs && !rsp_err) begin
      if (we_q) begin
        wr_count <= wr_count + 16'd1;
      end else begin
        rd_count <= rd_count + 16'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sam_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sam_dmem_responder
// Purpose  : Directed self-checking bench. Instance 0 has no wait states,
//            instance 1 has three.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sam_dmem_responder;

  logic        clk;
  logic        rn        [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_be    [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];
  logic [15:0] rd_count  [2];
  logic [15:0] wr_count  [2];

  int checks = 0;
  int errors = 0;

  sam_dmem_responder #(.DEPTH(32), .ADDR_W(5), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .RN(rn[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
    .rd_count(rd_count[0]), .wr_count(wr_count[0])
  );

  sam_dmem_responder #(.DEPTH(32), .ADDR_W(5), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .RN(rn[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
    .rd_count(rd_count[1]), .wr_count(wr_count[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request at a negedge and return once it has been accepted
  task automatic issue(input int d, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
    int t;
    @(negedge clk);
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    req_be[d]    = be;
    t = 0;
    while (!req_ready[d] && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("issue_ready", {31'd0, req_ready[d]}, 32'd1);
    @(negedge clk);
    req_valid[d] = 1'b0;
  endtask

  // Wait for the response, optionally stall it for 'hold' cycles, then accept it
  task automatic collect(input int d, input int hold, output logic [31:0] rdata,
                         output logic err, output int lat);
    int c;
    c = 0;
    while (!rsp_valid[d] && c < 40) begin
      @(negedge clk);
      c++;
    end
    lat   = c + 1;
    rdata = rsp_rdata[d];
    err   = rsp_err[d];
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_rdata", rsp_rdata[d], rdata);
      check("hold_err",   {31'd0, rsp_err[d]}, {31'd0, err});
      check("hold_valid", {31'd0, rsp_valid[d]}, 32'd1);
      check("hold_ready", {31'd0, req_ready[d]}, 32'd0);
    end
    rsp_ready[d] = 1'b1;
    @(negedge clk);
    rsp_ready[d] = 1'b0;
    check("rsp_dropped", {31'd0, rsp_valid[d]}, 32'd0);
  endtask

  task automatic txn(input string tag, input int d, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be, input int hold,
                     input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
    logic [31:0] r;
    logic        e;
    int          l;
    issue(d, we, addr, wdata, be);
    collect(d, hold, r, e, l);
    check({tag, "_rdata"}, r, exp_rdata);
    check({tag, "_err"},   {31'd0, e}, {31'd0, exp_err});
    check({tag, "_lat"},   l, exp_lat);
  endtask

  task automatic check_idle(input string tag, input int d);
    check({tag, "_req_ready"}, {31'd0, req_ready[d]}, 32'd1);
    check({tag, "_rsp_valid"}, {31'd0, rsp_valid[d]}, 32'd0);
    check({tag, "_rdata"},     rsp_rdata[d], 32'd0);
    check({tag, "_err"},       {31'd0, rsp_err[d]}, 32'd0);
    check({tag, "_rd_count"},  {16'd0, rd_count[d]}, 32'd0);
    check({tag, "_wr_count"},  {16'd0, wr_count[d]}, 32'd0);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rn[d] = 1'b0; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0;
      req_wdata[d] = '0; req_be[d] = '0; rsp_ready[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rn[0] = 1'b1;
    rn[1] = 1'b1;
    check_idle("reset0", 0);
    check_idle("reset3", 1);

    // Basic store then load, zero wait states
    txn("st3", 0, 1'b1, 32'd3, 32'h0000001E, 4'hF, 0, 32'h0, 1'b0, 2);
    txn("ld3", 0, 1'b0, 32'd3, 32'h0,        4'h0, 0, 32'h1E, 1'b0, 2);
    check("cnt1_wr", {16'd0, wr_count[0]}, 32'd1);
    check("cnt1_rd", {16'd0, rd_count[0]}, 32'd1);

    // Byte enables: only bytes 0 and 2 replaced
    txn("st5a", 0, 1'b1, 32'd5, 32'hAABBCCDD, 4'hF,    0, 32'h0, 1'b0, 2);
    txn("st5b", 0, 1'b1, 32'd5, 32'h11223344, 4'b0101, 0, 32'h0, 1'b0, 2);
    txn("ld5",  0, 1'b0, 32'd5, 32'h0,        4'h0,    0, 32'hAA22CC44, 1'b0, 2);
    // Zero byte-enable store is a counted no-op
    txn("st5z", 0, 1'b1, 32'd5, 32'hFFFFFFFF, 4'h0,    0, 32'h0, 1'b0, 2);
    txn("ld5z", 0, 1'b0, 32'd5, 32'h0,        4'h0,    0, 32'hAA22CC44, 1'b0, 2);
    check("cnt2_wr", {16'd0, wr_count[0]}, 32'd4);
    check("cnt2_rd", {16'd0, rd_count[0]}, 32'd3);

    // Out-of-range accesses: error, zero data, no write, no count
    txn("st1",   0, 1'b1, 32'd1,        32'hDEADBEEF, 4'hF, 0, 32'h0, 1'b0, 2);
    txn("ld32",  0, 1'b0, 32'd32,       32'h0,        4'h0, 0, 32'h0, 1'b1, 2);
    txn("stbig", 0, 1'b1, 32'h80000001, 32'h12345678, 4'hF, 0, 32'h0, 1'b1, 2);
    check("cnt3_wr", {16'd0, wr_count[0]}, 32'd5);
    check("cnt3_rd", {16'd0, rd_count[0]}, 32'd3);
    txn("ld1",   0, 1'b0, 32'd1,        32'h0,        4'h0, 0, 32'hDEADBEEF, 1'b0, 2);
    check("cnt3b_rd", {16'd0, rd_count[0]}, 32'd4);

    // Three wait states with response backpressure
    txn("w_st2", 1, 1'b1, 32'd2, 32'hCAFEF00D, 4'hF, 0, 32'h0, 1'b0, 5);
    txn("w_ld2", 1, 1'b0, 32'd2, 32'h0,        4'h0, 5, 32'hCAFEF00D, 1'b0, 5);
    check("w_cnt_wr", {16'd0, wr_count[1]}, 32'd1);
    check("w_cnt_rd", {16'd0, rd_count[1]}, 32'd1);

    // Reset during WAIT discards the in-flight store
    txn("w_st7", 1, 1'b1, 32'd7, 32'd9, 4'hF, 0, 32'h0, 1'b0, 5);
    issue(1, 1'b1, 32'd7, 32'h55555555, 4'hF);
    rn[1] = 1'b0;
    @(negedge clk);
    rn[1] = 1'b1;
    check_idle("midrst", 1);
    txn("w_ld7", 1, 1'b0, 32'd7, 32'h0, 4'h0, 0, 32'd9, 1'b0, 5);
    check("midrst_rd", {16'd0, rd_count[1]}, 32'd1);

    // Load counter wrap from 16'hFFFF
    @(negedge clk);
    force dut0.rd_count = 16'hFFFF;
    @(negedge clk);
    release dut0.rd_count;
    txn("wrap_ld", 0, 1'b0, 32'd3, 32'h0, 4'h0, 0, 32'h1E, 1'b0, 2);
    check("wrap_rd", {16'd0, rd_count[0]}, 32'd0);
    check("wrap_wr", {16'd0, wr_count[0]}, 32'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
